// File: rtl/clock_counter.sv
// clock_counter: wall-clock time keeper (hours/minutes/seconds in binary).
// Advances on the 1 Hz tick from clk_gen. Time is set by holding the
// hours/minutes buttons, which step at the slow or fast set rate.
// Every time update raises o_time_stb for one cycle.
module clock_counter #(
  parameter int RESET_HOURS   = 0,
  parameter int RESET_MINUTES = 0,
  parameter int RESET_SECONDS = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_1hz_stb,
  input  logic       i_slow_set_stb,
  input  logic       i_fast_set_stb,
  input  logic       i_fast_set,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_setting,
  output logic       o_time_stb
);

  localparam logic [4:0] HOURS_INIT   = 5'(RESET_HOURS);
  localparam logic [5:0] MINUTES_INIT = 6'(RESET_MINUTES);
  localparam logic [5:0] SECONDS_INIT = 6'(RESET_SECONDS);

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [4:0] hours, hours_next;
  logic [5:0] minutes, minutes_next;
  logic [5:0] seconds, seconds_next;
  logic       time_stb, time_stb_next;

  logic btn;
  logic set_stb;

  // Hours counter step, wrapping 23 -> 0.
  function automatic logic [4:0] inc_hours(input logic [4:0] v);
    if (v >= 5'd23) return 5'd0;
    return v + 5'd1;
  endfunction

  // Minutes/seconds counter step, wrapping 59 -> 0.
  function automatic logic [5:0] inc_sixty(input logic [5:0] v);
    if (v >= 6'd59) return 6'd0;
    return v + 6'd1;
  endfunction

  assign btn     = i_set_hours | i_set_minutes;
  assign set_stb = i_fast_set ? i_fast_set_stb : i_slow_set_stb;

  // Next-state and next-time logic: counting in RUN, per-field stepping in SET.
  always_comb begin
    state_next    = state;
    hours_next    = hours;
    minutes_next  = minutes;
    seconds_next  = seconds;
    time_stb_next = 1'b0;

    unique case (state)
      RUN: begin
        if (btn) begin
          // Entering SET clears seconds and gives the held field(s) an
          // immediate step; a coincident 1 Hz tick is deliberately dropped.
          state_next    = SET;
          seconds_next  = 6'd0;
          if (i_set_hours)   hours_next   = inc_hours(hours);
          if (i_set_minutes) minutes_next = inc_sixty(minutes);
          time_stb_next = 1'b1;
        end else if (i_1hz_stb) begin
          // Full ripple carry so 23:59:59 rolls to 00:00:00 in one edge.
          seconds_next = inc_sixty(seconds);
          if (seconds >= 6'd59) begin
            minutes_next = inc_sixty(minutes);
            if (minutes >= 6'd59) hours_next = inc_hours(hours);
          end
          time_stb_next = 1'b1;
        end
      end
      SET: begin
        if (!btn) begin
          // Release wins over a coincident set strobe: leave with no step.
          state_next = RUN;
        end else if (set_stb) begin
          // Fields step independently; no carry from minutes into hours.
          if (i_set_hours)   hours_next   = inc_hours(hours);
          if (i_set_minutes) minutes_next = inc_sixty(minutes);
          seconds_next  = 6'd0;
          time_stb_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State and time registers; async reset loads the configured start time.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= RUN;
      hours    <= HOURS_INIT;
      minutes  <= MINUTES_INIT;
      seconds  <= SECONDS_INIT;
      time_stb <= 1'b0;
    end else begin
      state    <= state_next;
      hours    <= hours_next;
      minutes  <= minutes_next;
      seconds  <= seconds_next;
      time_stb <= time_stb_next;
    end
  end

  assign o_hours    = hours;
  assign o_minutes  = minutes;
  assign o_seconds  = seconds;
  assign o_setting  = (state == SET);
  assign o_time_stb = time_stb;

endmodule

// File: doc/clock_counter.md
Name: clock_counter

Overview:
Consumes the strobes produced by clk_gen (1 Hz tick, slow and fast set strobes) and maintains the wall-clock time as binary hours/minutes/seconds for the display path.
Runs in i_clk domain, downstream of clk_gen and upstream of the BCD/7-segment encoder.
Handles time-setting from two pre-debounced, synchronized button levels.
Flags every time change with a one-cycle strobe so the display path refreshes only when needed.

Parameters:
RESET_HOURS, 0, hours value loaded on reset (0..23)
RESET_MINUTES, 0, minutes value loaded on reset (0..59)
RESET_SECONDS, 0, seconds value loaded on reset (0..59)

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  reset; asynchronous assert, active-low
i_1hz_stb  input  1  one-cycle 1 Hz tick from clk_gen
i_slow_set_stb  input  1  one-cycle slow set-rate tick from clk_gen
i_fast_set_stb  input  1  one-cycle fast set-rate tick from clk_gen
i_fast_set  input  1  level; 1 selects i_fast_set_stb as the set rate, 0 selects i_slow_set_stb
i_set_hours  input  1  level; hours-set button held (already debounced, synchronous to i_clk)
i_set_minutes  input  1  level; minutes-set button held (already debounced, synchronous to i_clk)
o_hours  output  5  current hours, 0..23
o_minutes  output  6  current minutes, 0..59
o_seconds  output  6  current seconds, 0..59
o_setting  output  1  1 while in SET state
o_time_stb  output  1  one-cycle pulse in the cycle after any of o_hours/o_minutes/o_seconds changes

Behaviour:
- Reset (i_reset_n=0, async): o_hours=RESET_HOURS, o_minutes=RESET_MINUTES, o_seconds=RESET_SECONDS, o_setting=0, o_time_stb=0, state=RUN.
- All outputs are registered. An input sampled high at rising edge N gives updated outputs from edge N onward, visible in cycle N+1. o_time_stb is high in that same cycle N+1 only.
- Define btn = i_set_hours | i_set_minutes. Define set_stb = i_fast_set ? i_fast_set_stb : i_slow_set_stb.
- States: RUN, SET.
- RUN, btn=0: on i_1hz_stb do seconds+1.
  - 59 -> 0 with carry to minutes+1.
  - minutes 59 -> 0 with carry to hours+1.
  - hours 23 -> 0.
  - 23:59:59 -> 00:00:00 in a single edge, with one o_time_stb.
- RUN, btn=1: go to SET. On the same edge:
  - seconds <- 0.
  - If i_set_hours, hours +1 (23 -> 0).
  - If i_set_minutes, minutes +1 (59 -> 0).
  - An i_1hz_stb coincident with this edge is dropped.
  - o_time_stb pulses even if the values are unchanged.
- SET, btn=1: on set_stb, increment each selected field.
  - No carries between fields: minutes 59 -> 0 leaves hours unchanged.
  - seconds held at 0.
  - i_1hz_stb ignored.
  - The unselected set strobe is ignored.
- SET, btn=0: return to RUN on that edge with no increment. The first i_1hz_stb after that edge advances seconds 0 -> 1.
- Both buttons held: both fields increment on the same edge. A single o_time_stb is produced.
- Button change within SET (e.g. hours released, minutes still held): stay in SET. Only the still-held field increments on later set_stb.
- set_stb and btn falling on the same edge: btn=0 has priority; no increment.
- i_fast_set may change at any time; it takes effect on the next edge.
- Reset mid-SET: immediate return to the reset values and RUN, regardless of button state. After reset release with a button held, the first edge enters SET as described above.
- o_setting = (state == SET), registered.

Test Plan:
- Reset with defaults, release, apply 3 i_1hz_stb pulses -> 00:00:03. o_time_stb pulses 3 times, each exactly one cycle, one cycle after each strobe.
- RESET_HOURS=23, RESET_MINUTES=59, RESET_SECONDS=58, apply 2 i_1hz_stb -> 23:59:59 then 00:00:00. Exactly one o_time_stb per tick.
- From 10:59:30, hold i_set_minutes with i_fast_set=0 -> the entry edge gives 10:00:00 and o_setting=1. Then 3 i_slow_set_stb -> 10:03:00, with i_fast_set_stb and i_1hz_stb pulses ignored.
- From 23:00:00, hold both buttons with i_fast_set=1 -> the entry edge gives 00:01:00. Then 2 i_fast_set_stb -> 02:03:00. Release both -> o_setting=0, and the next i_1hz_stb gives 02:03:01.
- i_1hz_stb coincident with the i_set_hours rising edge at 05:20:10 -> 06:20:00. The tick is dropped and a single o_time_stb is produced.
- Assert i_reset_n=0 mid-SET with buttons held -> outputs return to the reset values asynchronously and o_setting=0. Release reset with buttons still held -> the next edge re-enters SET with an increment.
